// File: rtl/compare_pkg.sv
// Shared encodings and sizing helpers for the sequential comparator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package compare_pkg;

    // Operation encodings carried on Select; 3'b110 and 3'b111 are reserved.
    typedef enum logic [2:0] {
        OP_EQ  = 3'b000,
        OP_GT  = 3'b001,
        OP_LT  = 3'b010,
        OP_MAX = 3'b011,
        OP_MIN = 3'b100,
        OP_GE  = 3'b101
    } op_e;

    // Controller states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int DEFAULT_WIDTH = 8;

    // Bit-counter width for a given operand width: clog2(width), never below 1.
    function automatic int cnt_width(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

    localparam int CNT_W = cnt_width(DEFAULT_WIDTH);

endpackage

// File: rtl/bit_compare_cell.sv
// One-bit magnitude cell: reports whether x beats y and whether they match.
// Latency: purely combinational.
// Backpressure: none.
module bit_compare_cell (
    input  logic x,
    input  logic y,
    input  logic invert,
    output logic greater,
    output logic same
);

    // With invert set (sign bit of signed operands) a 0 outranks a 1.
    assign same    = ~(x ^ y);
    assign greater = invert ? (~x & y) : (x & ~y);

endmodule

// File: rtl/seq_compare_unit.sv
// Bit-serial MSB-first comparator producing EQ/GT/LT/MAX/MIN/GE results.
// Latency: Done in the cycle after the last examined bit (1..WIDTH scan cycles).
// Backpressure: Start is ignored while Busy; results hold until the next Done.
module seq_compare_unit
    import compare_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             Clock,
    input  logic             Reset_n,
    input  logic             Start,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    input  logic [2:0]       Select,
    input  logic             Signed,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Out,
    output logic             Eq,
    output logic             Gt,
    output logic             Lt
);

    localparam int             CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    state_e           r_state;
    state_e           w_state_nxt;
    logic [WIDTH-1:0] r_x;
    logic [WIDTH-1:0] r_y;
    op_e              r_sel;
    logic             r_signed;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_out;
    logic             r_eq;
    logic             r_gt;
    logic             r_lt;

    logic             w_accept;
    logic [CW-1:0]    w_idx;
    logic             w_x_bit;
    logic             w_y_bit;
    logic             w_invert;
    logic             w_greater;
    logic             w_same;
    logic             w_last;
    logic [WIDTH-1:0] w_out;

    // Start only lands outside SCAN, so an in-flight scan cannot be disturbed.
    assign w_accept = Start && (r_state != ST_SCAN);

    // Scan cycle i looks at bit WIDTH-1-i; the sign bit is the first one seen.
    assign w_idx    = LAST - r_cnt;
    assign w_x_bit  = r_x[w_idx];
    assign w_y_bit  = r_y[w_idx];
    assign w_invert = r_signed && (r_cnt == '0);

    bit_compare_cell u_cell (
        .x       (w_x_bit),
        .y       (w_y_bit),
        .invert  (w_invert),
        .greater (w_greater),
        .same    (w_same)
    );

    // Scan ends on the first mismatch or once bit 0 has been examined.
    assign w_last = (r_state == ST_SCAN) && (!w_same || (r_cnt == LAST));

    // Result word for the final bit pair; w_same here means all bits matched.
    always_comb begin
        w_out = '0;
        case (r_sel)
            OP_EQ:   w_out = {{(WIDTH-1){1'b0}}, w_same};
            OP_GT:   w_out = {{(WIDTH-1){1'b0}}, w_greater};
            OP_LT:   w_out = {{(WIDTH-1){1'b0}}, !w_same && !w_greater};
            OP_GE:   w_out = {{(WIDTH-1){1'b0}}, w_same || w_greater};
            OP_MAX:  w_out = w_greater ? r_x : r_y;
            OP_MIN:  w_out = w_greater ? r_y : r_x;
            default: w_out = '0;
        endcase
    end

    // State register.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode plus the state-derived Busy/Done strobes.
    always_comb begin
        w_state_nxt = r_state;
        Busy        = 1'b0;
        Done        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (Start) w_state_nxt = ST_SCAN;
            end
            ST_SCAN: begin
                Busy = 1'b1;
                if (w_last) w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                Done        = 1'b1;
                w_state_nxt = Start ? ST_SCAN : ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Operand capture, bit counter and result registers.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            r_x      <= '0;
            r_y      <= '0;
            r_sel    <= OP_EQ;
            r_signed <= 1'b0;
            r_cnt    <= '0;
            r_out    <= '0;
            r_eq     <= 1'b0;
            r_gt     <= 1'b0;
            r_lt     <= 1'b0;
        end else begin
            if (w_accept) begin
                r_x      <= X;
                r_y      <= Y;
                r_sel    <= op_e'(Select);
                r_signed <= Signed;
                r_cnt    <= '0;
            end else if ((r_state == ST_SCAN) && !w_last) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_last) begin
                r_out <= w_out;
                r_eq  <= w_same;
                r_gt  <= w_greater;
                r_lt  <= !w_same && !w_greater;
            end
        end
    end

    assign Out = r_out;
    assign Eq  = r_eq;
    assign Gt  = r_gt;
    assign Lt  = r_lt;

endmodule

// File: tb/tb_seq_compare_unit.sv
// Directed bench for seq_compare_unit: vector table plus multi-cycle sequences.
// Latency: checks Done timing as n+1 cycles counting the Start cycle as cycle 0.
// Backpressure: exercises Start while Busy and Start in the Done cycle.
module tb_seq_compare_unit;

    logic       Clock;
    logic       Reset_n;
    logic       Start;
    logic [7:0] X;
    logic [7:0] Y;
    logic [2:0] Select;
    logic       Signed;
    logic       Busy;
    logic       Done;
    logic [7:0] Out;
    logic       Eq;
    logic       Gt;
    logic       Lt;

    int checks = 0;
    int errors = 0;

    seq_compare_unit #(.WIDTH(8)) dut (
        .Clock   (Clock),
        .Reset_n (Reset_n),
        .Start   (Start),
        .X       (X),
        .Y       (Y),
        .Select  (Select),
        .Signed  (Signed),
        .Busy    (Busy),
        .Done    (Done),
        .Out     (Out),
        .Eq      (Eq),
        .Gt      (Gt),
        .Lt      (Lt)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    typedef struct {
        logic [7:0] x;
        logic [7:0] y;
        logic [2:0] sel;
        logic       sgn;
        logic [7:0] out;
        logic       eq;
        logic       gt;
        logic       lt;
        int         n;
    } vec_t;

    vec_t vecs [13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Present one Start cycle; returns at the sample point after the accept edge.
    task automatic start_op(input logic [7:0] x, input logic [7:0] y,
                            input logic [2:0] sel, input logic sgn);
        Start  = 1'b1;
        X      = x;
        Y      = y;
        Select = sel;
        Signed = sgn;
        @(posedge Clock);
        #1;
        Start  = 1'b0;
        X      = 8'($urandom);
        Y      = 8'($urandom);
        Select = 3'($urandom);
        Signed = 1'($urandom);
    endtask

    // Wait (bounded) for Done, counting cycles and Busy cycles on the way.
    task automatic wait_done(input int c0, output int cyc, output int nbusy);
        cyc   = c0;
        nbusy = 0;
        while (!Done && cyc < 40) begin
            if (Busy) nbusy++;
            @(posedge Clock);
            #1;
            cyc++;
        end
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int cyc;
        int nb;
        start_op(v.x, v.y, v.sel, v.sgn);
        wait_done(1, cyc, nb);
        check({tag, "_latency"}, cyc, v.n + 1);
        check({tag, "_busy_cycles"}, nb, v.n);
        check({tag, "_busy_at_done"}, {31'b0, Busy}, 32'd0);
        check({tag, "_out"}, {24'b0, Out}, {24'b0, v.out});
        check({tag, "_eq"}, {31'b0, Eq}, {31'b0, v.eq});
        check({tag, "_gt"}, {31'b0, Gt}, {31'b0, v.gt});
        check({tag, "_lt"}, {31'b0, Lt}, {31'b0, v.lt});
    endtask

    initial begin
        int cyc;
        int nb;
        int done_seen;

        //          x      y      sel     sgn   out    eq gt lt  n
        vecs[0]  = '{8'hA5, 8'h25, 3'b001, 1'b0, 8'h01, 0, 1, 0, 1};
        vecs[1]  = '{8'h3C, 8'h3C, 3'b000, 1'b0, 8'h01, 1, 0, 0, 8};
        vecs[2]  = '{8'h80, 8'h01, 3'b011, 1'b1, 8'h01, 0, 0, 1, 1};
        vecs[3]  = '{8'h80, 8'h01, 3'b011, 1'b0, 8'h80, 0, 1, 0, 1};
        vecs[4]  = '{8'h0F, 8'h0E, 3'b100, 1'b0, 8'h0E, 0, 1, 0, 8};
        vecs[5]  = '{8'h10, 8'h20, 3'b010, 1'b0, 8'h01, 0, 0, 1, 3};
        vecs[6]  = '{8'h7F, 8'h7F, 3'b101, 1'b1, 8'h01, 1, 0, 0, 8};
        vecs[7]  = '{8'h40, 8'h41, 3'b101, 1'b0, 8'h00, 0, 0, 1, 8};
        vecs[8]  = '{8'hFF, 8'h01, 3'b100, 1'b1, 8'hFF, 0, 0, 1, 1};
        vecs[9]  = '{8'h55, 8'hAA, 3'b110, 1'b0, 8'h00, 0, 0, 1, 1};
        vecs[10] = '{8'h22, 8'h22, 3'b011, 1'b0, 8'h22, 1, 0, 0, 8};
        vecs[11] = '{8'h33, 8'h33, 3'b100, 1'b0, 8'h33, 1, 0, 0, 8};
        vecs[12] = '{8'hFE, 8'hFF, 3'b001, 1'b1, 8'h00, 0, 0, 1, 8};

        // Reset held low with Start asserted: everything stays cleared.
        Reset_n = 1'b0;
        Start   = 1'b1;
        X       = 8'hA5;
        Y       = 8'h25;
        Select  = 3'b001;
        Signed  = 1'b0;
        repeat (3) @(posedge Clock);
        #1;
        check("reset_busy", {31'b0, Busy}, 32'd0);
        check("reset_done", {31'b0, Done}, 32'd0);
        check("reset_out",  {24'b0, Out},  32'd0);
        check("reset_eqgtlt", {29'b0, Eq, Gt, Lt}, 32'd0);
        Start   = 1'b0;
        Reset_n = 1'b1;
        @(posedge Clock);
        #1;

        for (int i = 0; i < 13; i++) begin
            run_vec(vecs[i], $sformatf("v%0d", i));
            @(posedge Clock);
            #1;
        end

        // Start during the scan is ignored; Start in the Done cycle chains a new op.
        start_op(8'h0F, 8'h0E, 3'b100, 1'b0);
        repeat (2) @(posedge Clock);
        #1;
        start_op(8'hFF, 8'h00, 3'b011, 1'b0);
        check("midscan_start_busy", {31'b0, Busy}, 32'd1);
        wait_done(4, cyc, nb);
        check("midscan_start_latency", cyc, 32'd9);
        check("midscan_start_out", {24'b0, Out}, 32'h0E);
        check("midscan_start_gt", {31'b0, Gt}, 32'd1);
        start_op(8'hA5, 8'h25, 3'b001, 1'b0);
        check("b2b_busy", {31'b0, Busy}, 32'd1);
        check("b2b_done_low", {31'b0, Done}, 32'd0);
        check("b2b_out_held", {24'b0, Out}, 32'h0E);
        wait_done(1, cyc, nb);
        check("b2b_latency", cyc, 32'd2);
        check("b2b_out", {24'b0, Out}, 32'h01);
        @(posedge Clock);
        #1;
        check("done_one_cycle", {31'b0, Done}, 32'd0);

        // Reset in the middle of a scan aborts it with no later Done pulse.
        start_op(8'h55, 8'h55, 3'b000, 1'b0);
        repeat (2) @(posedge Clock);
        #1;
        Reset_n = 1'b0;
        #1;
        check("abort_busy", {31'b0, Busy}, 32'd0);
        check("abort_done", {31'b0, Done}, 32'd0);
        check("abort_out",  {24'b0, Out},  32'd0);
        check("abort_gt",   {31'b0, Gt},   32'd0);
        @(posedge Clock);
        #1;
        Reset_n   = 1'b1;
        done_seen = 0;
        for (int k = 0; k < 15; k++) begin
            @(posedge Clock);
            #1;
            if (Done || Busy) done_seen++;
        end
        check("abort_no_done", done_seen, 32'd0);
        run_vec(vecs[1], "after_abort");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_compare_unit.md
SEQ_COMPARE_UNIT -- requirements
Module: seq_compare_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width in bits; legal range 2..32.
REQ-002 SHALL have input Clock, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have input Reset_n, 1 bit: reset, asynchronous, active-low.
REQ-004 SHALL have input Start, 1 bit: request to latch operands and begin a comparison.
REQ-005 SHALL have input X, WIDTH bits: operand A, sampled only when Start is accepted.
REQ-006 SHALL have input Y, WIDTH bits: operand B, sampled only when Start is accepted.
REQ-007 SHALL have input Select, 3 bits: operation, sampled with X/Y.
- 000 EQ
- 001 GT
- 010 LT
- 011 MAX
- 100 MIN
- 101 GE
- 110 and 111 reserved.
REQ-008 SHALL have input Signed, 1 bit: 1 = two's-complement operands, 0 = unsigned; sampled with X/Y.
REQ-009 SHALL have output Busy, 1 bit: high while a scan is in progress.
REQ-010 SHALL have output Done, 1 bit: one-cycle pulse marking Out/Eq/Gt/Lt valid.
REQ-011 SHALL have output Out, WIDTH bits: operation result.
REQ-012 SHALL have outputs Eq, Gt, Lt, 1 bit each: relation of latched X to latched Y.

Function
REQ-013 SHALL implement FSM states IDLE, SCAN, DONE.
REQ-014 SHALL accept Start in IDLE or DONE; on accept, latch X/Y/Select/Signed, clear the bit counter and enter SCAN next edge.
REQ-015 SHALL ignore Start while in SCAN; latched operands and progress are unaffected.
REQ-016 SHALL compare one bit pair per SCAN cycle, MSB first, bit index WIDTH-1-i on scan cycle i.
REQ-017 SHALL, in signed mode, treat the MSB pair inverted: X sign 1 and Y sign 0 means X<Y.
REQ-018 SHALL terminate the scan on the first differing bit pair, or after bit 0, entering DONE next edge with Eq/Gt/Lt registered.
REQ-019 SHALL give Done latency of n+1 cycles after the Start-accept edge, where n = bits examined, 1..WIDTH.
REQ-020 SHALL, when the scan runs to bit 0 with all bits equal, set Eq=1, Gt=0, Lt=0.
REQ-021 SHALL produce Out per operation:
- EQ/GT/LT/GE: zero-extended 1-bit flag.
- MAX: larger operand, or Y when equal.
- MIN: smaller operand, or X when equal.
- Reserved: all zeros with Eq/Gt/Lt still valid.
REQ-022 SHALL hold Done high for exactly the DONE cycle, then return to IDLE unless Start is accepted in that cycle.
REQ-023 SHALL hold Out/Eq/Gt/Lt stable from DONE until the next DONE, including through a subsequent SCAN.
REQ-024 SHALL assert Busy exactly in SCAN; Busy and Done are never high together.

Reset
REQ-025 SHALL, on Reset_n low, immediately force state IDLE, Busy=0, Done=0, Out=0, Eq=0, Gt=0, Lt=0, counter=0 and clear latched operands.
REQ-026 SHALL abort a scan in progress on reset mid-operation, with no Done pulse afterwards.
REQ-027 SHALL ignore Start during the first rising edge after Reset_n deasserts only if Reset_n is still low at that edge.

Structure
REQ-028 SHALL place the Select encodings, FSM state encodings and a counter-width constant, clog2(WIDTH), in a shared package, compare_pkg.
REQ-029 SHALL use one sub-module, bit_compare_cell: a 1-bit cell with inputs x, y, invert and outputs greater, same, instantiated once in the scan datapath.

Verification
REQ-030 SHALL check reset: Reset_n low with Start=1 -> Busy=0, Done=0, Out=0x00, Eq=Gt=Lt=0.
REQ-031 SHALL check early termination: WIDTH=8, X=0xA5, Y=0x25, GT, unsigned -> Done 2 cycles after Start, Out=0x01, Gt=1.
REQ-032 SHALL check a full scan: X=Y=0x3C, EQ -> Busy for 8 cycles, Done at cycle 9, Out=0x01, Eq=1.
REQ-033 SHALL check signed handling with X=0x80, Y=0x01, MAX:
- Signed=1 -> Out=0x01, Lt=1.
- Signed=0 -> Out=0x80, Gt=1.
REQ-034 SHALL check Start during Busy ignored and back-to-back operation: X=0x0F/Y=0x0E MIN, re-Start with X=0xFF mid-scan -> Out=0x0E; Start in DONE cycle -> new Busy next cycle.
REQ-035 SHALL check reset mid-scan: assert Reset_n low in scan cycle 3 of X=Y=0x55 -> no Done, outputs 0, next Start completes normally.
